seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
Time-multiplexed driver for the 4-digit common-anode seven-segment display on the board. It sits directly downstream of the memory-mapped display register and consumes that register's 16-bit output, which is the bitwise complement of the software-written value. It shows the value as four hex digits, with anti-ghosting blank time and tear-free per-scan snapshots. It runs on the free-running board clock and ignores CPU clock-enable/stepping.

Parameters:
DIGIT_CYCLES, 50000, clock cycles per digit slot; must be >= 2.
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; 1 <= BLANK_CYCLES < DIGIT_CYCLES.
LZ_BLANK, 0, 1 = suppress leading zero digits (digit 0 is never suppressed).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
value_n  input  16  complemented display value from the MMIO display register
seg_n  output  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}
dp_n  output  1  decimal point, active-low; held 1 (always off)
an_n  output  4  digit anodes, active-low; an_n[i] drives digit i; digit 0 = value[3:0]
digit_idx  output  2  digit slot currently being scanned (debug/verification)

Behaviour:
- Reset values, effective at the first clk edge with rst=1 and held while rst=1:
  - an_n=4'hF, seg_n=7'h7F, dp_n=1, digit_idx=0.
  - Internal state: slot counter=0, snapshot=16'h0, state=BLANK.
- Slot counter:
  - Counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - digit_idx increments on each wrap, 3->0 modulo 4.
- State machine, a function of the counter:
  - BLANK while counter < BLANK_CYCLES.
  - DRIVE for the rest of the slot.
  - Transitions are BLANK->DRIVE at counter==BLANK_CYCLES and DRIVE->BLANK at the wrap.
- Snapshot:
  - snapshot <= ~value_n on the edge leaving the cycle where counter==0 and digit_idx==0. This includes the first cycle after rst deasserts.
  - Changes to value_n at any other time are not visible until the next scan.
- Outputs are registered:
  - During BLANK: an_n=4'hF and seg_n=7'h7F.
  - During DRIVE: an_n has only bit digit_idx low, and seg_n = decode(snapshot nibble digit_idx).
  - Output registers update on the same edge as the state/counter. an_n is therefore low for exactly DIGIT_CYCLES-BLANK_CYCLES consecutive cycles per slot, preceded by BLANK_CYCLES cycles of all-off.
- The full scan period is exactly 4*DIGIT_CYCLES cycles, and each digit is lit once per scan.
- Hex decode, active-high {g..a} values; seg_n is the complement:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Leading-zero blanking (LZ_BLANK=1):
  - Digit i (i>=1) is suppressed when snapshot nibbles i..3 are all zero.
  - A suppressed digit keeps an_n all-high and seg_n=7'h7F for its whole slot.
  - Timing is unchanged.
- Boundary cases:
  - Reset asserted mid-slot: reset values appear the next edge. The scan restarts at digit 0 BLANK after deassertion, with a fresh snapshot.
  - value_n changing on the snapshot cycle: the value sampled at that edge wins.
- No combinational path from value_n to any output.

Decomposition:
- Package display_pkg holds:
  - NUM_DIGITS=4.
  - The scanner state enum (BLANK, DRIVE).
  - The function hex_to_seg(nibble) returning active-high {g..a}.
- Sub-module hex_to_seven_seg: purely combinational wrapper around hex_to_seg, instantiated once on the selected nibble.
- The scanner instantiates the sub-module and owns all sequential logic.

Test Plan:
All scenarios use DIGIT_CYCLES=8 and BLANK_CYCLES=2.
- Reset: rst=1 for 3 cycles with arbitrary value_n -> an_n=F, seg_n=7F, dp_n=1, digit_idx=0 throughout.
- Basic scan: value_n=~16'h1234, release rst -> four slots in order:
  - digit 0: an_n=E, seg_n=19 ('4')
  - digit 1: an_n=D, seg_n=30 ('3')
  - digit 2: an_n=B, seg_n=24 ('2')
  - digit 3: an_n=7, seg_n=79 ('1')
  - Each slot is 2 cycles all-off then 6 cycles lit.
- Timing: count the cycles -> an_n[0] low exactly 6 cycles, repeating every 32 cycles; never two an_n bits low at once.
- Tearing: start with value 0x1234, change value_n to ~16'hABCD during the digit-1 DRIVE phase:
  - Digits 2 and 3 still show 2 and 1.
  - The next scan shows digit 0: seg_n=21 ('d'), digit 1: 46 ('C'), digit 2: 03 ('b'), digit 3: 08 ('A').
- Leading zeros with LZ_BLANK=1:
  - value 0x0050 -> digits 3 and 2 stay off (an_n=F), digit 1 shows seg_n=12 ('5'), digit 0 shows seg_n=40 ('0').
  - value 0x0000 -> only digit 0 lit, showing seg_n=40.
- Reset mid-operation: rst=1 for 1 cycle during the digit-2 DRIVE phase:
  - The next edge gives an_n=F and digit_idx=0.
  - After release, digit 0 begins with 2 blank cycles and shows the newly snapshotted value.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display path.
//   NUM_DIGITS   : number of multiplexed digits on the board
//   scan_state_e : scanner slot phase (all anodes off, or digit lit)
//   hex_to_seg   : hex nibble to active-high segment pattern {g,f,e,d,c,b,a}
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic {
    StBlank,
    StDrive
  } scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Display bundle between the MMIO display register and the scanner.
//   value_n   : complemented display value (register side drives)
//   seg_n     : segment cathodes, active-low, {g,f,e,d,c,b,a}
//   dp_n      : decimal point, active-low
//   an_n      : digit anodes, active-low, bit i = digit i
//   digit_idx : slot currently being scanned
// master = register/board side, slave = scanner.
interface seven_segment_scanner_if;
  import display_pkg::*;

  logic [15:0]           value_n;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic [1:0]            digit_idx;

  modport master (output value_n, input seg_n, dp_n, an_n, digit_idx);
  modport slave  (input value_n, output seg_n, dp_n, an_n, digit_idx);

endinterface

// File: rtl/hex_to_seven_seg.sv
// Combinational hex digit decoder.
//   nibble : 4-bit hex value
//   seg    : active-high segment pattern {g,f,e,d,c,b,a}
module hex_to_seven_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit slot lasts DIGIT_CYCLES clocks; the first BLANK_CYCLES of it keep
// every anode off to avoid ghosting. The displayed value is captured once per
// scan so a digit never mixes two software writes.
//   clk  : free-running board clock
//   rst  : synchronous reset, active-high
//   disp : slave side of the display bundle (value_n in, segment/anode out)
module seven_segment_scanner
  import display_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          LZ_BLANK     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_segment_scanner_if.slave  disp
);

  localparam int unsigned CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CntMax   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BlankCnt = CW'(BLANK_CYCLES);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  scan_state_e           state_q, state_d;
  logic [15:0]           snap_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  wrap;
  logic [3:0]            nibble;
  logic [6:0]            seg_on;
  logic                  suppress;

  hex_to_seven_seg u_dec (
    .nibble (nibble),
    .seg    (seg_on)
  );

  always_comb begin
    wrap  = (cnt_q == CntMax);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;

    state_d = state_q;
    if (wrap) begin
      state_d = StBlank;
    end else if (state_q == StBlank && cnt_d == BlankCnt) begin
      state_d = StDrive;
    end

    // DRIVE never starts on a wrap, so the current index is the one lit next.
    nibble   = 4'h0;
    suppress = 1'b0;
    unique case (idx_q)
      2'd0: begin
        nibble   = snap_q[3:0];
        suppress = 1'b0;
      end
      2'd1: begin
        nibble   = snap_q[7:4];
        suppress = (snap_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble   = snap_q[11:8];
        suppress = (snap_q[15:8] == 8'h00);
      end
      default: begin
        nibble   = snap_q[15:12];
        suppress = (snap_q[15:12] == 4'h0);
      end
    endcase
    suppress = suppress & LZ_BLANK;
  end

  // Outputs are computed from the next state so they change on the same edge
  // as the counter and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      state_q <= StBlank;
      snap_q  <= 16'h0000;
      an_q    <= '1;
      seg_q   <= 7'h7F;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      if (cnt_q == '0 && idx_q == 2'd0) begin
        snap_q <= ~disp.value_n;
      end
      if (state_d == StDrive && !suppress) begin
        an_q  <= ~(NUM_DIGITS'(1) << idx_q);
        seg_q <= ~seg_on;
      end else begin
        an_q  <= '1;
        seg_q <= 7'h7F;
      end
    end
  end

  assign disp.an_n      = an_q;
  assign disp.seg_n     = seg_q;
  assign disp.dp_n      = 1'b1;
  assign disp.digit_idx = idx_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Two instances run in lockstep off one reset: dut0 without and dut1 with
// leading-zero blanking. A slot-position model tracks counter and digit.
module tb_seven_segment_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_scanner_if if0 ();
  seven_segment_scanner_if if1 ();

  seven_segment_scanner #(
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2),
    .LZ_BLANK     (1'b0)
  ) dut0 (
    .clk  (clk),
    .rst  (rst),
    .disp (if0.slave)
  );

  seven_segment_scanner #(
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2),
    .LZ_BLANK     (1'b1)
  ) dut1 (
    .clk  (clk),
    .rst  (rst),
    .disp (if1.slave)
  );

  // Expected active-low patterns packed {digit3, digit2, digit1, digit0}.
  localparam logic [27:0] S1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] SABCD = {7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [27:0] S00F0 = {7'h40, 7'h40, 7'h0E, 7'h40};
  localparam logic [27:0] S0050 = {7'h40, 7'h40, 7'h12, 7'h40};
  localparam logic [27:0] S0000 = {7'h40, 7'h40, 7'h40, 7'h40};

  int n_checks  = 0;
  int n_errors  = 0;
  int cycnum    = 0;
  int m_cnt     = 0;
  int m_idx     = 0;
  int run0      = 0;
  int last_fall = -1;
  bit track_en  = 1'b0;
  logic prev_an0 = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycnum);
    end
  endtask

  // Advance one clock, update the model, then check both instances.
  task automatic cyc(input logic [27:0] segs0, input logic [27:0] segs1, input logic [3:0] lit1);
    logic [3:0] ea0, ea1;
    logic [6:0] es0, es1;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_idx = 0;
    end else if (m_cnt == 7) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt++;
    end
    cycnum++;
    #1;
    ea0 = 4'hF;
    es0 = 7'h7F;
    ea1 = 4'hF;
    es1 = 7'h7F;
    if (m_cnt >= 2) begin
      ea0 = ~(4'b0001 << m_idx);
      es0 = segs0[m_idx*7 +: 7];
      if (lit1[m_idx]) begin
        ea1 = ~(4'b0001 << m_idx);
        es1 = segs1[m_idx*7 +: 7];
      end
    end
    check_eq("an0", if0.an_n, ea0);
    check_eq("seg0", if0.seg_n, es0);
    check_eq("dp0", if0.dp_n, 1);
    check_eq("idx0", if0.digit_idx, m_idx);
    check_eq("an1", if1.an_n, ea1);
    check_eq("seg1", if1.seg_n, es1);
    check_eq("idx1", if1.digit_idx, m_idx);
    check_eq("an0_onehot", ($countones(~if0.an_n) <= 1), 1);

    if (!if0.an_n[0]) begin
      run0++;
      if (prev_an0) begin
        if (track_en && last_fall >= 0) check_eq("an0_period", cycnum - last_fall, 32);
        last_fall = track_en ? cycnum : -1;
      end
    end else if (run0 != 0) begin
      check_eq("an0_run", run0, 6);
      run0 = 0;
    end
    prev_an0 = if0.an_n[0];
  endtask

  initial begin
    if0.value_n = 16'h5A5A;
    if1.value_n = 16'hFFFF;
    repeat (3) cyc(S1234, S0050, 4'b0011);

    // Release with 0x1234 on dut0 and 0x0050 on dut1.
    if0.value_n = ~16'h1234;
    if1.value_n = ~16'h0050;
    rst         = 1'b0;
    track_en    = 1'b1;
    repeat (32) cyc(S1234, S0050, 4'b0011);

    // Change mid digit-1 DRIVE; rest of this scan must keep the old snapshot.
    for (int i = 0; i < 32; i++) begin
      cyc(S1234, S0050, 4'b0011);
      if (m_idx == 1 && m_cnt == 4) if0.value_n = ~16'hABCD;
    end
    repeat (32) cyc(SABCD, S0050, 4'b0011);

    // Stop in digit-2 DRIVE and pulse reset for one cycle.
    track_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cyc(SABCD, S0050, 4'b0011);
      if (m_idx == 2 && m_cnt == 4) break;
    end
    check_eq("reached_d2_drive", (m_idx == 2 && m_cnt == 4), 1);
    if0.value_n = ~16'h00F0;
    if1.value_n = ~16'h0000;
    rst         = 1'b1;
    cyc(S00F0, S0000, 4'b0001);
    rst = 1'b0;
    repeat (32) cyc(S00F0, S0000, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
